mat_scan_scheduler: RTL and testbench

Frame-scan sequencer for the matrix (window) datapath. Handles one start pulse at a time and, for each, drives a pixel-memory read stream over a W×H frame. In step with each fetch it advances the 31-slot register-bank write pointer and the lagging calculate pointer. It emits window-center addresses, calculate strobes and border flags, then drains the pipeline and pulses done.

---
 rtl/mat_scan_scheduler_if.sv | 31 +++
 rtl/mat_scan_scheduler.sv | 118 +++++++++++
 tb/tb_mat_scan_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mat_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
// mat_scan_scheduler_if
// Control/read-stream bundle between the frame-scan sequencer and its users.
// Revision: 1.0
// ============================================================================
interface mat_scan_scheduler_if;
  logic        start;
  logic        abort;
  logic        mem_ready;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [4:0]  slot_wr;
  logic [4:0]  slot_cal;
  logic        cal_en;
  logic [15:0] center_addr;
  logic        border;
  logic        busy;
  logic        done;

  modport master (
    input  start, abort, mem_ready,
    output rd_en, rd_addr, slot_wr, slot_cal, cal_en, center_addr, border, busy, done
  );

  modport slave (
    output start, abort, mem_ready,
    input  rd_en, rd_addr, slot_wr, slot_cal, cal_en, center_addr, border, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mat_scan_scheduler.sv
`default_nettype none
// ============================================================================
// mat_scan_scheduler
// Frame-scan sequencer: pixel read stream, bank slot pointers, window centers.
// Revision: 1.0
// ============================================================================
module mat_scan_scheduler #(
  parameter int W          = 360,
  parameter int H          = 120,
  parameter int LAG_OFFSET = 722,
  parameter int SLOTS      = 31,
  parameter int LAG        = 2,
  parameter int MARGIN     = 2
) (
  input  logic                 clk,
  input  logic                 nRESET,
  mat_scan_scheduler_if.master bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [15:0]   c_LAST_FETCH = 16'(W * H - 1);
  localparam logic [15:0]   c_LAST_FLUSH = 16'(W * H + LAG_OFFSET - 1);
  localparam logic [15:0]   c_LAG_OFFSET = 16'(LAG_OFFSET);
  localparam logic [4:0]    c_SLOT_LAST  = 5'(SLOTS - 1);
  localparam logic [4:0]    c_LAG        = 5'(LAG);
  localparam logic [4:0]    c_LAG_WRAP   = 5'(SLOTS - LAG);
  localparam logic [CW-1:0] c_COL_LAST   = CW'(W - 1);
  localparam logic [CW-1:0] c_COL_LO     = CW'(MARGIN);
  localparam logic [CW-1:0] c_COL_HI     = CW'(W - MARGIN);
  localparam logic [RW-1:0] c_ROW_LAST   = RW'(H - 1);
  localparam logic [RW-1:0] c_ROW_LO     = RW'(MARGIN);
  localparam logic [RW-1:0] c_ROW_HI     = RW'(H - MARGIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_pos;
  logic [4:0]    r_slotWr;
  logic [CW-1:0] r_ccol;
  logic [RW-1:0] r_crow;

  logic          w_accept;
  logic          w_advance;
  logic          w_calEn;
  logic [4:0]    w_slotCal;
  logic          w_edge;

  assign w_accept  = (r_state == S_FETCH) && bus.mem_ready;
  assign w_advance = w_accept || (r_state == S_FLUSH);
  assign w_calEn   = (w_accept && (r_pos >= c_LAG_OFFSET)) || (r_state == S_FLUSH);
  assign w_slotCal = (r_slotWr >= c_LAG) ? (r_slotWr - c_LAG) : (r_slotWr + c_LAG_WRAP);
  assign w_edge    = (r_ccol < c_COL_LO) || (r_ccol >= c_COL_HI) ||
                     (r_crow < c_ROW_LO) || (r_crow >= c_ROW_HI);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_IDLE;
      r_pos    <= '0;
      r_slotWr <= '0;
      r_ccol   <= '0;
      r_crow   <= '0;
    end else if (bus.abort) begin
      // Counters are left as-is; the next start clears them.
      r_state <= S_IDLE;
    end else begin
      if (w_advance) begin
        r_pos    <= r_pos + 16'd1;
        r_slotWr <= (r_slotWr == c_SLOT_LAST) ? 5'd0 : r_slotWr + 5'd1;
      end
      if (w_calEn) begin
        if (r_ccol == c_COL_LAST) begin
          r_ccol <= '0;
          r_crow <= (r_crow == c_ROW_LAST) ? '0 : r_crow + RW'(1);
        end else begin
          r_ccol <= r_ccol + CW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_FETCH;
            r_pos    <= '0;
            r_slotWr <= '0;
            r_ccol   <= '0;
            r_crow   <= '0;
          end
        end
        S_FETCH: begin
          if (w_accept && (r_pos == c_LAST_FETCH)) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_pos == c_LAST_FLUSH) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en       = (r_state == S_FETCH);
  assign bus.rd_addr     = r_pos;
  assign bus.slot_wr     = r_slotWr;
  assign bus.slot_cal    = w_slotCal;
  assign bus.cal_en      = w_calEn;
  assign bus.center_addr = r_pos - c_LAG_OFFSET;
  assign bus.border      = w_calEn && w_edge;
  assign bus.busy        = (r_state == S_FETCH) || (r_state == S_FLUSH);
  assign bus.done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mat_scan_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mat_scan_scheduler
// Directed bench for the frame-scan sequencer at W=8, H=6, LAG_OFFSET=18.
// Revision: 1.0
// ============================================================================
module tb_mat_scan_scheduler;

  logic clk = 1'b0;
  logic nRESET;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  mat_scan_scheduler_if bus ();

  mat_scan_scheduler #(
    .W(8), .H(6), .LAG_OFFSET(18), .SLOTS(31), .LAG(2), .MARGIN(2)
  ) dut (
    .clk    (clk),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic borderModel(input int ctr);
    int col, row;
    col = ctr % 8;
    row = ctr / 8;
    return (col < 2) || (col >= 6) || (row < 2) || (row >= 4);
  endfunction

  initial begin
    int calCount, nextAddr, stalls, doneCyc, pos;
    int wrapSw[4]  = '{29, 30, 0, 1};
    int wrapSc[4]  = '{27, 28, 29, 30};
    int bCtr[5]    = '{0, 18, 21, 22, 42};
    int bExp[5]    = '{1, 0, 0, 1, 1};

    nRESET = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    chk("rst_rd_en",    bus.rd_en,    0);
    chk("rst_rd_addr",  bus.rd_addr,  0);
    chk("rst_slot_wr",  bus.slot_wr,  0);
    chk("rst_slot_cal", bus.slot_cal, 29);
    chk("rst_cal_en",   bus.cal_en,   0);
    chk("rst_border",   bus.border,   0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    tick();
    nRESET = 1'b1;
    tick();

    // Full-rate frame: start sampled at edge k, loop index c is cycle k+c.
    bus.start = 1'b1;
    calCount = 0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      bus.start = 1'b0;
      #1;
      pos = c - 1;
      chk("full_rd_en", bus.rd_en, (c <= 48));
      chk("full_busy",  bus.busy,  (c <= 66));
      chk("full_done",  bus.done,  (c == 67));
      chk("full_cal_en", bus.cal_en, (c >= 19 && c <= 66));
      if (c <= 48) chk("full_rd_addr", bus.rd_addr, pos);
      if (c <= 66) begin
        chk("full_slot_wr",  bus.slot_wr,  pos % 31);
        chk("full_slot_cal", bus.slot_cal, (pos + 29) % 31);
      end
      if (c >= 30 && c <= 33) begin
        chk("wrap_slot_wr",  bus.slot_wr,  wrapSw[c-30]);
        chk("wrap_slot_cal", bus.slot_cal, wrapSc[c-30]);
      end
      if (c >= 19 && c <= 66) begin
        chk("full_center", bus.center_addr, pos - 18);
        chk("full_border", bus.border, borderModel(pos - 18));
        for (int i = 0; i < 5; i++)
          if (pos - 18 == bCtr[i]) chk("border_tab", bus.border, bExp[i]);
      end else begin
        chk("full_border_off", bus.border, 0);
      end
      if (bus.cal_en) calCount++;
    end
    chk("full_cal_count", calCount, 48);

    // Alternating mem_ready starting with ready in the first FETCH cycle.
    bus.start = 1'b1;
    calCount = 0;
    nextAddr = 0;
    stalls   = 0;
    doneCyc  = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      bus.start = 1'b0;
      bus.mem_ready = c[0];
      #1;
      if (bus.rd_en) begin
        chk("stall_rd_addr", bus.rd_addr, nextAddr);
        if (bus.mem_ready) nextAddr++;
        else begin
          stalls++;
          chk("stall_no_cal", bus.cal_en, 0);
        end
      end
      if (bus.cal_en) calCount++;
      if (bus.done) begin
        doneCyc = c;
        break;
      end
    end
    chk("stall_reads",     nextAddr, 48);
    chk("stall_cycles",    stalls,   47);
    chk("stall_done_cyc",  doneCyc,  114);
    chk("stall_cal_count", calCount, 48);
    bus.mem_ready = 1'b1;
    tick();

    // Abort mid-FETCH at rd_addr 10.
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = 1'b0;
      #1;
      if (bus.rd_en && bus.rd_addr == 16'd10) break;
    end
    chk("abort_at_addr", bus.rd_addr, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    #1;
    chk("abort_busy",  bus.busy,  0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_done",  bus.done,  0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", bus.done, 0);
    end

    // abort and start together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("abort_start_busy", bus.busy, 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    chk("restart_rd_en",   bus.rd_en,   1);
    chk("restart_rd_addr", bus.rd_addr, 0);
    chk("restart_slot_wr", bus.slot_wr, 0);

    // Abort on the final FETCH beat must not enter FLUSH.
    for (int c = 0; c < 60; c++) begin
      if (bus.rd_en && bus.rd_addr == 16'd47) break;
      tick();
      #1;
    end
    chk("final_at_addr", bus.rd_addr, 47);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    #1;
    chk("final_abort_busy",  bus.busy,   0);
    chk("final_abort_rd_en", bus.rd_en,  0);
    chk("final_abort_cal",   bus.cal_en, 0);
    tick();
    chk("final_abort_done",  bus.done,   0);

    // Asynchronous reset mid-FETCH.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_rd_en", bus.rd_en, 1);
    #2;
    nRESET = 1'b0;
    #1;
    chk("mid_rst_rd_en",    bus.rd_en,    0);
    chk("mid_rst_rd_addr",  bus.rd_addr,  0);
    chk("mid_rst_slot_wr",  bus.slot_wr,  0);
    chk("mid_rst_slot_cal", bus.slot_cal, 29);
    chk("mid_rst_cal_en",   bus.cal_en,   0);
    chk("mid_rst_border",   bus.border,   0);
    chk("mid_rst_busy",     bus.busy,     0);
    chk("mid_rst_done",     bus.done,     0);
    tick();
    nRESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_busy",  bus.busy,  0);
      chk("post_rst_rd_en", bus.rd_en, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
